// File: rtl/rr_arb_mux_4_1_if.sv
// Valid/ready bundle for the 4-channel round-robin arbiter: four producer lanes in, one merged stream out.
// The arbiter uses the slave modport and the environment drives it through the master modport.
interface rr_arb_mux_4_1_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;
  logic [WIDTH-1:0] in_data0;
  logic [WIDTH-1:0] in_data1;
  logic [WIDTH-1:0] in_data2;
  logic [WIDTH-1:0] in_data3;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;

  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb_mux_4_1.sv
// Four-channel round-robin arbiter with an integrated 4:1 data select and a one-deep registered
// valid/ready output stage. The channel that was just served drops to the lowest priority.
module rr_arb_mux_4_1 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  rr_arb_mux_4_1_if.slave  bus
);

  logic [1:0]       ptr_q,       ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [1:0]       out_sel_q,   out_sel_d;

  logic             grant_vld;
  logic [1:0]       grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             can_load;
  logic             xfer;

  // Descending scan so the candidate closest to ptr_q is written last and wins.
  always_comb begin : grant_search
    logic [1:0] cand;
    // NOTE: every always_comb output gets a default first; a path that skips an assignment infers a latch.
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (bus.in_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Only the granted lane is selected, so X on any other lane cannot reach the output.
  always_comb begin
    grant_data = bus.in_data0;
    case (grant_idx)
      2'd0:    grant_data = bus.in_data0;
      2'd1:    grant_data = bus.in_data1;
      2'd2:    grant_data = bus.in_data2;
      default: grant_data = bus.in_data3;
    endcase
  end

  assign can_load     = !out_valid_q || bus.out_ready;
  assign xfer         = grant_vld && can_load && !rst;
  assign bus.in_ready = xfer ? (4'b0001 << grant_idx) : 4'b0000;

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_sel_d   = grant_idx;
      ptr_d       = grant_idx + 2'd1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: doc/rr_arb_mux_4_1.md
Name: rr_arb_mux_4_1

Overview:
- Four-channel round-robin arbiter with an integrated 4:1 data select and a registered valid/ready output stage.
- Sits upstream of the 4:1 multiplexer-based datapath and produces both the channel select and the selected data word.
- Consumes four independent valid/ready producers and emits one merged stream tagged with the source channel index.
- Fairness: a channel that was just served drops to lowest priority.

Parameters:
- WIDTH, 4, data width of each input channel and of the output.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  4  per-channel request; bit i belongs to channel i.
- in_data0, in_data1, in_data2, in_data3  input  WIDTH each  per-channel payload.
- in_ready  output  4  per-channel accept; combinational.
- out_valid  output  1  registered; output holds a word.
- out_data  output  WIDTH  registered payload.
- out_sel  output  2  registered index of the source channel.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (rst=1 at a clock edge): out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0. While rst=1, in_ready=4'b0000 combinationally.
- Reset mid-operation: the held word is discarded without being delivered. No input transfer occurs in the reset cycle.
- Grant, combinational and one-hot or zero:
  - Search in_valid starting at index ptr, ascending and wrapping mod 4 (ptr, ptr+1, ptr+2, ptr+3).
  - The first set bit is granted.
  - No valid bits means no grant.
- Stage-free condition: can_load = !out_valid || out_ready.
- in_ready[i] = grant[i] && can_load && !rst. At most one in_ready bit is high in any cycle.
- in_ready depends on in_valid. Producers must not derive in_valid from in_ready.
- Transfer on channel i: in_valid[i] && in_ready[i] at a clock edge. On that edge:
  - out_data <= in_data_i
  - out_sel <= i
  - out_valid <= 1
  - ptr <= (i+1) mod 4
- Output drain: out_valid && out_ready with no simultaneous transfer gives out_valid <= 0. out_data and out_sel keep their last values.
- Simultaneous drain and load: out_valid && out_ready and a new transfer on the same edge means the new word replaces the old one and out_valid stays 1. This gives full throughput of one word per cycle.
- Back-pressure: out_valid && !out_ready means all in_ready are 0. out_valid, out_data and out_sel stay stable until accepted. ptr does not change.
- ptr advances only on a transfer. It never advances on idle cycles or stalls.
- Latency: input transfer at edge N gives the word visible on out_* after edge N, so 1 cycle.
- Wrap-around: ptr=3 with a transfer from channel 3 sets ptr to 0. ptr=2 with only channel 1 valid grants channel 1 and sets ptr to 2.
- Starvation bound: a continuously valid channel is granted within 4 transfers.
- in_data of non-granted channels is ignored. X on their data must not propagate.
- Data path: the select is a pure 4:1 choice over in_dataN by the grant index. No width change or arithmetic.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, all in_valid=0.
  - Required: out_valid=0, out_data=0, out_sel=0, in_ready=0000. After reset with in_valid=0, in_ready stays 0000.
- Single channel:
  - Stimulus: in_valid=0100, in_data2=4'hA, out_ready=1.
  - Required: in_ready=0100. Next cycle out_valid=1, out_data=A, out_sel=2. Internal ptr is now 3.
- Round-robin fairness:
  - Stimulus: in_valid=1111 held, data values 1, 2, 3, 4 on channels 0-3, out_ready=1.
  - Required: out_sel sequence 0,1,2,3,0,1 on consecutive cycles with out_data 1,2,3,4,1,2. out_valid=1 every cycle.
- Back-pressure:
  - Stimulus: load channel 1 with data 5, then out_ready=0 for 3 cycles with in_valid=1111.
  - Required: in_ready=0000 during the stall. out_data=5 and out_sel=1 stay stable. After out_ready=1, channel 2 transfers next.
- Wrap and skip:
  - Stimulus: set ptr to 3 by transferring on channel 2, then in_valid=0010.
  - Required: channel 1 is granted, and the next ptr is 2.
- Reset mid-stream:
  - Stimulus: out_valid=1 holding a word with out_ready=0, assert rst for 1 cycle with in_valid=1111.
  - Required: out_valid=0 and no transfer in that cycle. After reset, channel 0 is granted first.
